// File: rtl/sequenciador_servo_base.sv
// sequenciador_servo_base: sequences the rotating-base servo of the cube robot.
// Takes absolute position commands over an iniciar/pronto handshake and drives
// the 2-bit position code to the base PWM controller. Completion is held back
// for a settle time proportional to the angular distance travelled.
// Optional build macro: SEQ_SERVO_BASE_PASSO_UNICO_EN (fixed single-step settle).
module sequenciador_servo_base #(
  parameter int         TEMPO_PASSO  = 25000000,
  parameter logic [1:0] POS_INICIAL  = 2'b01,
  parameter int         LARGURA_CONT = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] alvo,
  output logic [1:0] posicao,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'b000,
    CARREGA = 3'b001,
    MOVE    = 3'b010,
    PRONTO  = 3'b011,
    ERRO    = 3'b100
  } estado_t;

  localparam logic [LARGURA_CONT-1:0] CARGA_UM = LARGURA_CONT'(TEMPO_PASSO - 1);
`ifdef SEQ_SERVO_BASE_PASSO_UNICO_EN
  localparam logic [LARGURA_CONT-1:0] CARGA_DOIS = CARGA_UM;
`else
  localparam logic [LARGURA_CONT-1:0] CARGA_DOIS = LARGURA_CONT'(2 * TEMPO_PASSO - 1);
`endif

  estado_t                 estado_q;
  logic [1:0]              alvo_q;
  logic [1:0]              posicao_q;
  logic [LARGURA_CONT-1:0] cont_q;
  logic                    ocupado_q;
  logic                    pronto_q;
  logic                    erro_q;

  logic [1:0]              passos_d;
  logic [LARGURA_CONT-1:0] carga_d;

  // Distance in 90-degree steps between latched target and current position,
  // and the settle-counter load that distance requires.
  always_comb begin
    passos_d = 2'd0;
    carga_d  = CARGA_UM;
    if (alvo_q >= posicao_q) begin
      passos_d = alvo_q - posicao_q;
    end else begin
      passos_d = posicao_q - alvo_q;
    end
    if (passos_d == 2'd2) begin
      carga_d = CARGA_DOIS;
    end
  end

  // Command FSM with registered outputs; posicao only ever loads a legal target.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      alvo_q    <= POS_INICIAL;
      posicao_q <= POS_INICIAL;
      cont_q    <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (iniciar) begin
            alvo_q    <= alvo;
            ocupado_q <= 1'b1;
            estado_q  <= CARREGA;
          end
        end
        CARREGA: begin
          if (alvo_q == 2'b11) begin
            ocupado_q <= 1'b0;
            erro_q    <= 1'b1;
            estado_q  <= ERRO;
          end else if (passos_d == 2'd0) begin
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b1;
            estado_q  <= PRONTO;
          end else begin
            posicao_q <= alvo_q;
            cont_q    <= carga_d;
            estado_q  <= MOVE;
          end
        end
        MOVE: begin
          if (cont_q == '0) begin
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b1;
            estado_q  <= PRONTO;
          end else begin
            cont_q <= cont_q - LARGURA_CONT'(1);
          end
        end
        PRONTO: begin
          estado_q <= OCIOSO;
        end
        ERRO: begin
          estado_q <= OCIOSO;
        end
        default: begin
          ocupado_q <= 1'b0;
          estado_q  <= OCIOSO;
        end
      endcase
    end
  end

  assign posicao   = posicao_q;
  assign ocupado   = ocupado_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_sequenciador_servo_base.sv
// Directed testbench for sequenciador_servo_base with TEMPO_PASSO=10.
// Honours SEQ_SERVO_BASE_PASSO_UNICO_EN for the two-step settle expectation.
module tb_sequenciador_servo_base;

  localparam int TP = 10;
`ifdef SEQ_SERVO_BASE_PASSO_UNICO_EN
  localparam int LAT_DOIS = 2 + TP;
`else
  localparam int LAT_DOIS = 2 + 2 * TP;
`endif
  localparam int LAT_UM = 2 + TP;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [1:0] alvo = 2'b00;
  logic [1:0] posicao;
  logic       ocupado;
  logic       pronto;
  logic       erro;
  logic [2:0] db_estado;

  int total = 0;
  int bad = 0;
  int prontoCount = 0;
  int erroCount = 0;

  sequenciador_servo_base #(
    .TEMPO_PASSO (TP),
    .POS_INICIAL (2'b01),
    .LARGURA_CONT(32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .iniciar  (iniciar),
    .alvo     (alvo),
    .posicao  (posicao),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .erro     (erro),
    .db_estado(db_estado)
  );

  // 100 MHz-style free-running clock (period only matters relative to TP).
  always #5 clock = ~clock;

  // Pulse counters; each pulse is one cycle wide so it is seen on one edge.
  always @(posedge clock) begin
    if (pronto) prontoCount++;
    if (erro) erroCount++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command: iniciar high across exactly one edge (E0); returns at E0+1.
  task automatic applyStimulus(input logic [1:0] a);
    alvo = a;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  // Wait (bounded) until pronto or erro; lat counts cycles after E0.
  task automatic waitDone(output int lat);
    lat = 1;
    while (!(pronto || erro) && lat <= 200) begin
      tick();
      lat++;
    end
    if (lat > 200) $display("[TB] FAIL timeout waiting for pronto/erro");
  endtask

  initial begin
    int lat;
    int pc;
    int ec;

    // Reset values while reset is held low
    tick();
    tick();
    checkOutput("rst_posicao", posicao, 2'b01);
    checkOutput("rst_ocupado", ocupado, 1'b0);
    checkOutput("rst_estado", db_estado, 3'b000);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("idle_posicao", posicao, 2'b01);
    checkOutput("idle_ocupado", ocupado, 1'b0);
    checkOutput("idle_pronto", pronto, 1'b0);
    checkOutput("idle_erro", erro, 1'b0);
    checkOutput("idle_estado", db_estado, 3'b000);

    // 01 -> 10, one step: detailed cycle-by-cycle timing
    pc = prontoCount;
    applyStimulus(2'b10);
    checkOutput("m1_ocupado_p1", ocupado, 1'b1);
    checkOutput("m1_posicao_p1", posicao, 2'b01);
    checkOutput("m1_estado_p1", db_estado, 3'b001);
    tick();
    checkOutput("m1_posicao_p2", posicao, 2'b10);
    checkOutput("m1_estado_p2", db_estado, 3'b010);
    for (int i = 3; i <= 11; i++) tick();
    checkOutput("m1_pronto_p11", pronto, 1'b0);
    checkOutput("m1_ocupado_p11", ocupado, 1'b1);
    tick();
    checkOutput("m1_pronto_p12", pronto, 1'b1);
    checkOutput("m1_ocupado_p12", ocupado, 1'b0);
    checkOutput("m1_estado_p12", db_estado, 3'b011);
    tick();
    checkOutput("m1_pronto_p13", pronto, 1'b0);
    checkOutput("m1_estado_p13", db_estado, 3'b000);
    checkOutput("m1_pronto_count", prontoCount - pc, 1);

    // 10 -> 00, two steps
    applyStimulus(2'b00);
    waitDone(lat);
    checkOutput("m2_latency", lat, LAT_DOIS);
    checkOutput("m2_pronto", pronto, 1'b1);
    checkOutput("m2_posicao", posicao, 2'b00);
    tick();

    // Illegal target
    pc = prontoCount;
    ec = erroCount;
    applyStimulus(2'b11);
    waitDone(lat);
    checkOutput("ill_latency", lat, 2);
    checkOutput("ill_erro", erro, 1'b1);
    checkOutput("ill_pronto", pronto, 1'b0);
    checkOutput("ill_posicao", posicao, 2'b00);
    checkOutput("ill_estado", db_estado, 3'b100);
    tick();
    checkOutput("ill_erro_clear", erro, 1'b0);
    checkOutput("ill_no_pronto", prontoCount - pc, 0);
    checkOutput("ill_erro_count", erroCount - ec, 1);

    // Same-position command
    applyStimulus(2'b00);
    waitDone(lat);
    checkOutput("same_latency", lat, 2);
    checkOutput("same_pronto", pronto, 1'b1);
    checkOutput("same_posicao", posicao, 2'b00);
    tick();

    // iniciar held high through MOVE and PRONTO with a different alvo
    pc = prontoCount;
    alvo = 2'b01;
    iniciar = 1'b1;
    tick();
    alvo = 2'b10;
    waitDone(lat);
    checkOutput("hold_latency", lat, LAT_UM);
    checkOutput("hold_posicao", posicao, 2'b01);
    tick();
    iniciar = 1'b0;
    checkOutput("hold_estado_after", db_estado, 3'b000);
    for (int i = 0; i < 30; i++) tick();
    checkOutput("hold_one_pronto", prontoCount - pc, 1);
    checkOutput("hold_posicao_final", posicao, 2'b01);
    checkOutput("hold_idle", db_estado, 3'b000);

    // Fresh command accepted after returning to OCIOSO
    applyStimulus(2'b10);
    waitDone(lat);
    checkOutput("fresh_latency", lat, LAT_UM);
    checkOutput("fresh_posicao", posicao, 2'b10);
    tick();

    // Reset five cycles into a two-step move
    applyStimulus(2'b00);
    for (int i = 2; i <= 5; i++) tick();
    checkOutput("abort_moving", posicao, 2'b00);
    pc = prontoCount;
    reset = 1'b0;
    #1;
    checkOutput("abort_posicao", posicao, 2'b01);
    checkOutput("abort_ocupado", ocupado, 1'b0);
    checkOutput("abort_estado", db_estado, 3'b000);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    checkOutput("abort_no_pronto", prontoCount - pc, 0);
    checkOutput("abort_posicao_held", posicao, 2'b01);

    // New command after release completes normally
    applyStimulus(2'b00);
    waitDone(lat);
    checkOutput("post_latency", lat, LAT_UM);
    checkOutput("post_posicao", posicao, 2'b00);
    checkOutput("post_pronto", pronto, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequenciador_servo_base.md
Name: sequenciador_servo_base

Overview:
- Sequences the rotating-base servo of the cube robot.
- Accepts absolute base-position commands from the top-level solver FSM over a start/done handshake, and drives the 2-bit position code into the base PWM servo controller.
- Holds off completion for a settle time proportional to the angular distance travelled, so the solver never grips or releases while the base is still turning.
- Rejects illegal position codes.

Parameters:
- TEMPO_PASSO, 25000000, settle cycles per 90° step (500 ms at 50 MHz); distance 0 => no wait.
- POS_INICIAL, 2'b01, position code driven from reset (01 = 90°, centre).
- LARGURA_CONT, 32, width of the settle counter; must hold 2*TEMPO_PASSO-1.

Ports:
- clock  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- iniciar  input  1  start request; sampled only in OCIOSO.
- alvo  input  2  target code: 00 = 0°, 01 = 90°, 10 = 180°, 11 = illegal.
- posicao  output  2  position code to the base servo PWM controller (registered).
- ocupado  output  1  high while a command is loading or moving.
- pronto  output  1  one-cycle pulse: move finished and settled.
- erro  output  1  one-cycle pulse: illegal target rejected.
- db_estado  output  3  current FSM state encoding (debug).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (while reset=0): state OCIOSO, posicao=POS_INICIAL, ocupado=0, pronto=0, erro=0, counter=0, latched target=POS_INICIAL.
- FSM states and encodings: OCIOSO=000, CARREGA=001, MOVE=010, PRONTO=011, ERRO=100.
- OCIOSO:
  - iniciar=1 at edge E0 -> CARREGA; alvo latched at E0.
  - iniciar=0 -> stay.
  - alvo is ignored after latching.
- CARREGA (ocupado=1):
  - Latched target 11 -> ERRO; posicao unchanged.
  - Otherwise passos = |target - posicao|, range 0..2, computed as unsigned difference.
  - passos=0 -> PRONTO directly.
  - Else -> MOVE; posicao<=target and counter<=passos*TEMPO_PASSO-1 at the same edge.
- MOVE (ocupado=1):
  - Counter decrements by 1 per cycle.
  - When counter==0 -> PRONTO.
  - MOVE lasts exactly passos*TEMPO_PASSO cycles.
- PRONTO: pronto=1, ocupado=0, single cycle -> OCIOSO.
- ERRO: erro=1, ocupado=0, single cycle -> OCIOSO.
- Latency for a legal move of passos>0:
  - ocupado rises 1 cycle after E0.
  - posicao changes 2 cycles after E0.
  - pronto asserts 2 + passos*TEMPO_PASSO cycles after E0.
- Latency for passos=0: pronto 2 cycles after E0.
- Latency for an illegal target: erro 2 cycles after E0.
- iniciar while not in OCIOSO (including PRONTO/ERRO) is ignored, not queued. The requester must wait for pronto or erro.
- pronto and erro are never high together; each is high for exactly one cycle per accepted command.
- Reset mid-MOVE: immediate return to reset values, so posicao reverts to POS_INICIAL asynchronously. No pronto is issued for the aborted command.
- All outputs are registered, and posicao is glitch-free. posicao never takes the value 11.

Optional Feature:
- SEQ_SERVO_BASE_PASSO_UNICO_EN
- Defined:
  - Each step costs TEMPO_PASSO regardless of distance: a 0°<->180° move also settles TEMPO_PASSO cycles, giving counter load TEMPO_PASSO-1 for any passos>0.
  - passos=0 behaviour is unchanged.
  - Intended for fast servos and for simulation.
- Undefined: distance-proportional settle as specified above.

Test Plan (simulation with TEMPO_PASSO=10):
- Reset release, then idle 5 cycles -> posicao=01, ocupado=0, pronto=0, erro=0, db_estado=000.
- From 01: alvo=10, iniciar pulse -> ocupado=1 at +1, posicao=10 at +2, pronto single pulse at +12, ocupado=0 from +12.
- From 10: alvo=00 -> pronto at +22 (feature off) or at +12 (SEQ_SERVO_BASE_PASSO_UNICO_EN defined); posicao=00.
- alvo=11 issued, and separately alvo equal to current position:
  - alvo=11 -> erro pulse at +2, posicao unchanged, no pronto.
  - Same-position command -> pronto at +2, no posicao change.
- Second iniciar held high during MOVE and PRONTO with a different alvo -> ignored; exactly one pronto; posicao matches the first target only. A fresh iniciar after OCIOSO is accepted.
- Reset asserted 5 cycles into a 2-step move -> posicao=01 immediately, ocupado=0, no pronto afterwards. A new command after release completes normally.
